// File: rtl/ks_pkg.sv
// Shared Kogge-Stone prefix-cell definitions for the adder/subtractor family.
// No build options in this file; the optional ovf datapath lives in ks_sub_pipe (KS_SUB_OVF_EN).
package ks_pkg;

  localparam int unsigned KS_DEFAULT_W = 16;
  localparam int unsigned KS_MAX_W     = 64;

  // Generate/propagate pair sized for the widest supported operand; narrower users slice the low W bits.
  typedef struct packed {
    logic [KS_MAX_W-1:0] g;
    logic [KS_MAX_W-1:0] p;
  } pg_t;

  function automatic int unsigned clog2_w(input int unsigned w);
    return $clog2(w);
  endfunction

  function automatic logic dot_g(input logic g_hi, input logic p_hi, input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

  function automatic logic dot_p(input logic p_hi, input logic p_lo);
    return p_hi & p_lo;
  endfunction

endpackage

// File: rtl/ks_prefix_row.sv
// One combinational Kogge-Stone prefix level: bit i merges with bit i-DIST.
module ks_prefix_row
  import ks_pkg::*;
#(
  parameter int unsigned W    = KS_DEFAULT_W,
  parameter int unsigned DIST = 1
) (
  input  logic [W-1:0] g,
  input  logic [W-1:0] p,
  output logic [W-1:0] g_next,
  output logic [W-1:0] p_next
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    if (i < DIST) begin : g_pass
      assign g_next[i] = g[i];
      assign p_next[i] = p[i];
    end else begin : g_dot
      assign g_next[i] = dot_g(g[i], p[i], g[i-DIST]);
      assign p_next[i] = dot_p(p[i], p[i-DIST]);
    end
  end

endmodule

// File: rtl/ks_sub_pipe.sv
// Fully pipelined Kogge-Stone subtractor (a - b - bin) with valid/ready stall.
// Build option: KS_SUB_OVF_EN adds a pipelined signed-overflow flag; otherwise ovf is tied low.
module ks_sub_pipe
  import ks_pkg::*;
#(
  parameter int unsigned W = KS_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int unsigned LVL = clog2_w(W);

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Index 0 is the S0 generate/propagate register; index k holds prefix level k.
  logic [W-1:0] g_q  [0:LVL];
  logic [W-1:0] p_q  [0:LVL];
  logic [W-1:0] pt_q [0:LVL];
  logic [LVL:0] c0_q;
  logic [LVL:0] vld_q;

  logic [W-1:0] g_row [1:LVL];
  logic [W-1:0] p_row [1:LVL];

  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    ks_prefix_row #(
      .W    (W),
      .DIST (32'(1) << (k - 1))
    ) u_row (
      .g      (g_q[k-1]),
      .p      (p_q[k-1]),
      .g_next (g_row[k]),
      .p_next (p_row[k])
    );
  end

  // Final carry resolution: group terms already span [i:0] after LVL levels.
  logic [W:0]   carry;
  logic [W-1:0] diff_c;
  logic         bout_c;

  always_comb begin
    carry    = '0;
    carry[0] = c0_q[LVL];
    for (int unsigned i = 1; i <= W; i++) begin
      carry[i] = g_q[LVL][i-1] | (p_q[LVL][i-1] & c0_q[LVL]);
    end
    diff_c = pt_q[LVL] ^ carry[W-1:0];
    bout_c = ~carry[W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= LVL; k++) begin
        g_q[k]  <= '0;
        p_q[k]  <= '0;
        pt_q[k] <= '0;
      end
      c0_q      <= '0;
      vld_q     <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
    end else if (!stall) begin
      g_q[0]  <= a & ~b;
      p_q[0]  <= a ^ ~b;
      pt_q[0] <= a ^ ~b;
      for (int unsigned k = 1; k <= LVL; k++) begin
        g_q[k]  <= g_row[k];
        p_q[k]  <= p_row[k];
        pt_q[k] <= pt_q[k-1];
      end
      c0_q      <= {c0_q[LVL-1:0], ~bin};
      vld_q     <= {vld_q[LVL-1:0], in_valid};
      out_valid <= vld_q[LVL];
      diff      <= diff_c;
      bout      <= bout_c;
    end
  end

`ifdef KS_SUB_OVF_EN
  // Operand sign bits ride alongside the data to form the overflow flag at the output stage.
  logic [LVL:0] sa_q;
  logic [LVL:0] sb_q;
  logic         ovf_c;

  assign ovf_c = (sa_q[LVL] ^ sb_q[LVL]) & (sa_q[LVL] ^ diff_c[W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa_q <= '0;
      sb_q <= '0;
      ovf  <= 1'b0;
    end else if (!stall) begin
      sa_q <= {sa_q[LVL-1:0], a[W-1]};
      sb_q <= {sb_q[LVL-1:0], b[W-1]};
      ovf  <= ovf_c;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ks_sub_pipe.sv
// Directed and scoreboarded bench for ks_sub_pipe at W=16, either ovf build.
module tb_ks_sub_pipe;

  localparam int unsigned W = 16;
`ifdef KS_SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  ks_sub_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_run;
  int   n_fail;
  int   n_pop;
  exp_t sb [$];
  exp_t cur_exp;
  exp_t mon_e;
  vec_t vecs [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    logic [W:0] t;
    exp_t       e;
    t      = {1'b0, av} - {1'b0, bv} - (W+1)'(bi);
    e.diff = t[W-1:0];
    e.bout = t[W];
    e.ovf  = OVF_ON & (av[W-1] ^ bv[W-1]) & (av[W-1] ^ t[W-1]);
    return e;
  endfunction

  function automatic exp_t exp_of(input vec_t v);
    exp_t e;
    e.diff = v.diff;
    e.bout = v.bout;
    e.ovf  = OVF_ON & v.ovf;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input exp_t e);
    a        = av;
    b        = bv;
    bin      = bi;
    cur_exp  = e;
    in_valid = 1'b1;
  endtask

  task automatic drive_rand();
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         bi;
    av = W'($urandom);
    bv = W'($urandom);
    bi = 1'($urandom);
    drive(av, bv, bi, model(av, bv, bi));
  endtask

  // Transfers are judged on the falling edge, where inputs and outputs are settled for the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("diff", 32'(diff), 32'(mon_e.diff));
          check("bout", 32'(bout), 32'(mon_e.bout));
          check("ovf",  32'(ovf),  32'(mon_e.ovf));
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int p0;
    int drop;
    int gaps;
    int bad;

    n_run  = 0;
    n_fail = 0;
    n_pop  = 0;
    //              a         b         bin   diff      bout  ovf
    vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[7] = '{16'h0001, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    cur_exp   = '0;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff",      32'(diff),      32'd0);
    check("rst_bout",      32'(bout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;

    // Single beat: first rising edge accepts it, sixth edge presents it.
    drive(vecs[0].a, vecs[0].b, vecs[0].bin, exp_of(vecs[0]));
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'd6);
    step();
    step();

    for (int i = 1; i < 8; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].bin, exp_of(vecs[i]));
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();
    check("dir_drain", 32'(sb.size()), 32'd0);

    // Back-to-back random stream with no backpressure.
    p0   = n_pop;
    drop = 0;
    gaps = 0;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      if (!in_ready) drop++;
      if (i >= 6 && !out_valid) gaps++;
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();
    check("rand_ready_drop", 32'(drop), 32'd0);
    check("rand_gaps",       32'(gaps), 32'd0);
    check("rand_pops",       32'(n_pop - p0), 32'd100);
    check("rand_drain",      32'(sb.size()), 32'd0);

    // Fill all six stages while the consumer is stalled, then hold for ten cycles.
    out_ready = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      step();
    end
    drive_rand();
    for (int i = 0; i < 10; i++) begin
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      if (sb.size() > 0) begin
        check("stall_diff", 32'(diff), 32'(sb[0].diff));
        check("stall_bout", 32'(bout), 32'(sb[0].bout));
      end else begin
        check("stall_sb_empty", 32'd1, 32'd0);
      end
      step();
    end
    // Release backpressure in the same cycle a new beat is offered.
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    repeat (12) step();
    check("stall_pops",  32'(n_pop - p0), 32'd7);
    check("stall_drain", 32'(sb.size()), 32'd0);

    // Reset with four beats in flight discards them all.
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    bad   = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) bad++;
    end
    check("flush_quiet", 32'(bad), 32'd0);

    drive(vecs[5].a, vecs[5].b, vecs[5].bin, exp_of(vecs[5]));
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check("latency_after_reset", 32'(n), 32'd6);
    repeat (3) step();
    check("final_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
